// File: rtl/ntt_pkg.sv
// ntt_pkg: shared NTT datapath defaults and the sparse-modulus correction constant builder
package ntt_pkg;
  localparam int LOGQ_DEF  = 64;
  localparam int REDUC_DEF = 17;
  localparam int TAG_W_DEF = 8;
  localparam int QR_W      = 64;
  function automatic logic [QR_W-1:0] qr_of(input logic [QR_W-1:0] q, input int rp);
    logic [QR_W-1:0] m;
    m = ((QR_W'(1) << rp) - QR_W'(1)) ^ QR_W'(1);
    return q & ~m;
  endfunction
endpackage

// File: rtl/modsub_if.sv
// modsub_if: valid/ready operand and result channels of the modular subtractor
interface modsub_if import ntt_pkg::*; #(
  parameter int LOGQ  = LOGQ_DEF,
  parameter int TAG_W = TAG_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [LOGQ-1:0]  A;
  logic [LOGQ-1:0]  B;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [LOGQ-1:0]  C;
  logic [TAG_W-1:0] out_tag;
  modport master (output in_valid, A, B, in_tag, out_ready, input in_ready, out_valid, C, out_tag);
  modport slave  (input in_valid, A, B, in_tag, out_ready, output in_ready, out_valid, C, out_tag);
endinterface

// File: rtl/modsub_core.sv
// modsub_core: combinational modular subtract, split into difference/borrow and correction halves
module modsub_core import ntt_pkg::*; #(
  parameter int LOGQ        = LOGQ_DEF,
  parameter int Reduc_param = REDUC_DEF
) (
  input  logic [LOGQ-1:0] a,
  input  logic [LOGQ-1:0] b,
  input  logic [LOGQ-1:0] q,
  input  logic [LOGQ-1:0] d_in,
  input  logic            borrow_in,
  output logic [LOGQ-1:0] d,
  output logic            borrow,
  output logic [LOGQ-1:0] c
);
  logic [LOGQ-1:0] qr;
  always_comb begin
    {borrow, d} = {1'b0, a} - {1'b0, b};
    qr = LOGQ'(qr_of(QR_W'(q), Reduc_param));
    c = borrow_in ? d_in + qr : d_in;
  end
endmodule

// File: rtl/modsub_pipe.sv
// modsub_pipe: two-stage pipelined (A - B) mod q with valid/ready backpressure and tag sideband
module modsub_pipe import ntt_pkg::*; #(
  parameter int LOGQ        = LOGQ_DEF,
  parameter int Reduc_param = REDUC_DEF,
  parameter int TAG_W       = TAG_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LOGQ-1:0] q,
  modsub_if.slave         io
);
  logic             en1, en2;
  logic             s1_valid_q, s1_valid_d, s1_borrow_q, s1_borrow_d;
  logic             s2_valid_q, s2_valid_d;
  logic [LOGQ-1:0]  s1_d_q, s1_d_d, c_q, c_d;
  logic [LOGQ-1:0]  d_comb, c_comb;
  logic             borrow_comb;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  modsub_core #(.LOGQ(LOGQ), .Reduc_param(Reduc_param)) u_core (
    .a(io.A), .b(io.B), .q(q), .d_in(s1_d_q), .borrow_in(s1_borrow_q),
    .d(d_comb), .borrow(borrow_comb), .c(c_comb)
  );
  // an empty stage always accepts, so bubbles collapse even while the consumer stalls
  always_comb begin
    en2         = ~s2_valid_q | io.out_ready;
    en1         = ~s1_valid_q | en2;
    s1_valid_d  = en1 ? io.in_valid : s1_valid_q;
    s1_d_d      = (en1 && io.in_valid) ? d_comb : s1_d_q;
    s1_borrow_d = (en1 && io.in_valid) ? borrow_comb : s1_borrow_q;
    s1_tag_d    = (en1 && io.in_valid) ? io.in_tag : s1_tag_q;
    s2_valid_d  = en2 ? s1_valid_q : s2_valid_q;
    c_d         = (en2 && s1_valid_q) ? c_comb : c_q;
    s2_tag_d    = (en2 && s1_valid_q) ? s1_tag_q : s2_tag_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_d_q      <= '0;
      s1_borrow_q <= 1'b0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      c_q         <= '0;
      s2_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_d_q      <= s1_d_d;
      s1_borrow_q <= s1_borrow_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      c_q         <= c_d;
      s2_tag_q    <= s2_tag_d;
    end
  end
  assign io.in_ready  = en1;
  assign io.out_valid = s2_valid_q;
  assign io.C         = c_q;
  assign io.out_tag   = s2_tag_q;
endmodule

// File: tb/tb_modsub_pipe.sv
// tb_modsub_pipe: directed vectors, stall/reset sequences and random scoreboard at 32 and 64 bits
module tb_modsub_pipe;
  localparam logic [63:0] Q32 = 64'h0000_0000_7FFF_E001;
  localparam logic [63:0] Q64 = 64'hFFFF_FFFF_0000_0001;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  modsub_if #(.LOGQ(32), .TAG_W(8)) i32 ();
  modsub_if #(.LOGQ(64), .TAG_W(8)) i64 ();
  modsub_pipe #(.LOGQ(32), .Reduc_param(13), .TAG_W(8)) u32 (.clk(clk), .rst(rst), .q(32'(Q32)), .io(i32));
  modsub_pipe #(.LOGQ(64), .Reduc_param(17), .TAG_W(8)) u64 (.clk(clk), .rst(rst), .q(Q64), .io(i64));
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  tag;
    logic [31:0] c;
  } vec_t;
  vec_t vt[7];
  function automatic logic [63:0] ref_sub(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q);
    return (a >= b) ? a - b : q - (b - a);
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
    i32.in_valid = v;
    i32.A = a;
    i32.B = b;
    i32.in_tag = tag;
  endtask
  // mode 0: 8 back-to-back beats on the 32-bit DUT with out_ready low in cycles 3-5
  // mode 1: random valid/ready and operands on both DUTs
  task automatic run(input int mode, input int n, input int maxc);
    int sent32 = 0, got32 = 0, sent64 = 0, got64 = 0, cyc = 0;
    logic [63:0] ec32[$], ec64[$];
    logic [7:0] et32[$], et64[$];
    logic hold32 = 1'b0, hold64 = 1'b0, saw_block = 1'b0;
    logic [63:0] hc32 = '0, hc64 = '0;
    logic [7:0] ht32 = '0, ht64 = '0;
    while ((got32 < n || (mode == 1 && got64 < n)) && cyc < maxc) begin
      i32.in_valid  = (sent32 < n) && (mode == 0 || $urandom_range(0, 3) != 0);
      i32.A         = (mode == 0) ? 32'(sent32 * 3) : 32'(64'($urandom) % Q32);
      i32.B         = (mode == 0) ? 32'(sent32 * 5 + 1) : 32'(64'($urandom) % Q32);
      i32.in_tag    = 8'(sent32);
      i32.out_ready = (mode == 0) ? !(cyc >= 3 && cyc <= 5) : ($urandom_range(0, 3) != 0);
      i64.in_valid  = (mode == 1) && (sent64 < n) && ($urandom_range(0, 3) != 0);
      i64.A         = {$urandom, $urandom} % Q64;
      i64.B         = {$urandom, $urandom} % Q64;
      i64.in_tag    = 8'(sent64 + 100);
      i64.out_ready = (mode == 0) || ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (hold32) begin
        chk("stall32_valid", 64'(i32.out_valid), 64'd1);
        chk("stall32_c", 64'(i32.C), hc32);
        chk("stall32_tag", 64'(i32.out_tag), 64'(ht32));
      end
      if (hold64) begin
        chk("stall64_valid", 64'(i64.out_valid), 64'd1);
        chk("stall64_c", i64.C, hc64);
        chk("stall64_tag", 64'(i64.out_tag), 64'(ht64));
      end
      hold32 = i32.out_valid && !i32.out_ready;
      hc32 = 64'(i32.C);
      ht32 = i32.out_tag;
      hold64 = i64.out_valid && !i64.out_ready;
      hc64 = i64.C;
      ht64 = i64.out_tag;
      if (i32.out_valid && i32.out_ready) begin
        if (ec32.size() == 0) chk("spurious32", 64'd1, 64'd0);
        else begin
          chk("out32_c", 64'(i32.C), ec32.pop_front());
          chk("out32_tag", 64'(i32.out_tag), 64'(et32.pop_front()));
        end
        got32++;
      end
      if (i64.out_valid && i64.out_ready) begin
        if (ec64.size() == 0) chk("spurious64", 64'd1, 64'd0);
        else begin
          chk("out64_c", i64.C, ec64.pop_front());
          chk("out64_tag", 64'(i64.out_tag), 64'(et64.pop_front()));
        end
        got64++;
      end
      if (i32.in_valid && !i32.in_ready) saw_block = 1'b1;
      if (i32.in_valid && i32.in_ready) begin
        ec32.push_back(ref_sub(64'(i32.A), 64'(i32.B), Q32));
        et32.push_back(i32.in_tag);
        sent32++;
      end
      if (i64.in_valid && i64.in_ready) begin
        ec64.push_back(ref_sub(i64.A, i64.B, Q64));
        et64.push_back(i64.in_tag);
        sent64++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    i32.in_valid = 1'b0;
    i64.in_valid = 1'b0;
    chk("drain32_count", 64'(got32), 64'(n));
    if (mode == 1) chk("drain64_count", 64'(got64), 64'(n));
    if (mode == 0) chk("backpressure_in_ready_low", 64'(saw_block), 64'd1);
  endtask
  initial begin
    vt[0] = '{32'd5, 32'd3, 8'h11, 32'd2};
    vt[1] = '{32'd3, 32'd5, 8'h22, 32'h7FFF_DFFF};
    vt[2] = '{32'd0, 32'h7FFF_E000, 8'h33, 32'd1};
    vt[3] = '{32'h1234, 32'h1234, 8'h44, 32'd0};
    vt[4] = '{32'h7FFF_E000, 32'd0, 8'h55, 32'h7FFF_E000};
    vt[5] = '{32'h4000_0000, 32'h1000_0000, 8'h66, 32'h3000_0000};
    vt[6] = '{32'd1, 32'h7FFF_E000, 8'h77, 32'd2};
    drive(1'b0, '0, '0, '0);
    i32.out_ready = 1'b1;
    i64.in_valid = 1'b0;
    i64.A = '0;
    i64.B = '0;
    i64.in_tag = '0;
    i64.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_out_valid", 64'(i32.out_valid), 64'd0);
    chk("reset_c", 64'(i32.C), 64'd0);
    chk("reset_tag", 64'(i32.out_tag), 64'd0);
    chk("reset_in_ready", 64'(i32.in_ready), 64'd1);
    chk("reset64_out_valid", 64'(i64.out_valid), 64'd0);
    chk("reset64_in_ready", 64'(i64.in_ready), 64'd1);
    foreach (vt[k]) begin
      drive(1'b1, vt[k].a, vt[k].b, vt[k].tag);
      tick();
      chk("vec_lat1_valid", 64'(i32.out_valid), 64'd0);
      drive(1'b0, '0, '0, '0);
      tick();
      chk("vec_lat2_valid", 64'(i32.out_valid), 64'd1);
      chk("vec_c", 64'(i32.C), 64'(vt[k].c));
      chk("vec_tag", 64'(i32.out_tag), 64'(vt[k].tag));
      tick();
      chk("vec_drained", 64'(i32.out_valid), 64'd0);
    end
    run(0, 8, 60);
    // bubble collapse: X moves to stage 2 under stall, Y fills stage 1, Z is refused
    i32.out_ready = 1'b0;
    drive(1'b1, 32'd9, 32'd4, 8'hA1);
    tick();
    drive(1'b0, '0, '0, '0);
    tick();
    chk("bubble_x_valid", 64'(i32.out_valid), 64'd1);
    chk("bubble_x_c", 64'(i32.C), 64'd5);
    chk("bubble_in_ready", 64'(i32.in_ready), 64'd1);
    drive(1'b1, 32'd4, 32'd9, 8'hA2);
    tick();
    chk("full_in_ready", 64'(i32.in_ready), 64'd0);
    drive(1'b1, 32'd100, 32'd1, 8'hA3);
    tick();
    chk("full_hold_c", 64'(i32.C), 64'd5);
    chk("full_hold_tag", 64'(i32.out_tag), 64'hA1);
    chk("full_hold_in_ready", 64'(i32.in_ready), 64'd0);
    i32.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(i32.in_ready), 64'd1);
    tick();
    drive(1'b0, '0, '0, '0);
    chk("release_y_c", 64'(i32.C), 64'h7FFF_DFFC);
    chk("release_y_tag", 64'(i32.out_tag), 64'hA2);
    tick();
    chk("release_z_c", 64'(i32.C), 64'd99);
    chk("release_z_tag", 64'(i32.out_tag), 64'hA3);
    tick();
    chk("release_empty", 64'(i32.out_valid), 64'd0);
    // reset with two beats in flight
    i32.out_ready = 1'b0;
    drive(1'b1, 32'd7, 32'd2, 8'hB1);
    tick();
    drive(1'b1, 32'd8, 32'd2, 8'hB2);
    tick();
    rst = 1'b1;
    drive(1'b1, 32'd50, 32'd2, 8'hB3);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, '0);
    chk("midreset_out_valid", 64'(i32.out_valid), 64'd0);
    chk("midreset_c", 64'(i32.C), 64'd0);
    chk("midreset_in_ready", 64'(i32.in_ready), 64'd1);
    i32.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midreset_no_stale", 64'(i32.out_valid), 64'd0);
    end
    run(1, 10000, 60000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
